// File: rtl/io_bus_master_pkg.sv
// Shared types and constants for the IO bus master.
package io_bus_master_pkg;

    localparam int DATA_W = 32;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        REQ_1,
        ACK_1,
        REQ_2,
        ACK_2,
        RESP
    } bus_master_state_t;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [DATA_W-1:0] status;
        logic              timeout;
    } bus_rsp_t;

endpackage

// File: rtl/io_bus_master_if.sv
// Internal IO bus: address/RW setup plus the two-phase 4-way handshake.
interface io_bus_master_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0] reg_address;
    logic              rw;
    logic              register_address_valid;
    logic [DATA_W-1:0] data_out;
    logic              handshake_1;
    logic              handshake_2;
    logic [DATA_W-1:0] data_in;

    modport master (
        output reg_address, rw, register_address_valid, data_out, handshake_1,
        input  handshake_2, data_in
    );

    modport slave (
        input  reg_address, rw, register_address_valid, data_out, handshake_1,
        output handshake_2, data_in
    );
endinterface

// File: rtl/io_bus_master_sync_2ff.sv
// Single-bit two-flop synchronizer for the subsystem acknowledge.
module io_bus_master_sync_2ff (
    input  logic clk,
    input  logic reset,
    input  logic i_d,
    output logic o_q
);
    logic r_meta;
    logic r_sync;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;
endmodule

// File: rtl/io_bus_master.sv
// Single master of the internal IO bus: one host command -> one bus transaction.
// Build option IO_BUS_MASTER_SYNC_EN synchronizes handshake_2 before the FSM.
//
// state | meaning
// IDLE  | cmd_ready high, waiting for a host command
// SETUP | address/RW on the bus, one cycle for subsystem decode
// REQ_1 | handshake_1 high, waiting for ack (read data captured here)
// ACK_1 | handshake_1 low, waiting for ack release
// REQ_2 | handshake_1 high, waiting for ack (status captured here)
// ACK_2 | handshake_1 low, waiting for ack release
// RESP  | rsp_valid high until the host takes it
module io_bus_master #(
    parameter int ADDR_W         = 8,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 1000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_cmd_valid,
    output logic              o_cmd_ready,
    input  logic              i_cmd_rw,
    input  logic [ADDR_W-1:0] i_cmd_addr,
    input  logic [DATA_W-1:0] i_cmd_data,
    output logic              o_rsp_valid,
    input  logic              i_rsp_ready,
    output logic [DATA_W-1:0] o_rsp_data,
    output logic [DATA_W-1:0] o_rsp_status,
    output logic              o_rsp_timeout,
    io_bus_master_if.master   bus
);
    import io_bus_master_pkg::*;

    localparam int             CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    bus_master_state_t r_state;
    logic              r_cmd_ready;
    logic              r_rsp_valid;
    logic              r_rsp_timeout;
    logic [DATA_W-1:0] r_rsp_data;
    logic [DATA_W-1:0] r_rsp_status;
    logic [ADDR_W-1:0] r_addr;
    logic              r_rw;
    logic              r_rav;
    logic [DATA_W-1:0] r_data_out;
    logic              r_h1;
    logic [CNT_W-1:0]  r_cnt;

    logic              w_h2;
    logic [DATA_W-1:0] w_din;
    logic              w_phase_done;

`ifdef IO_BUS_MASTER_SYNC_EN
    logic [DATA_W-1:0] r_din_q;

    io_bus_master_sync_2ff u_sync_h2 (
        .clk   (clk),
        .reset (reset),
        .i_d   (bus.handshake_2),
        .o_q   (w_h2)
    );

    // Subsystem holds data_in until handshake_1 falls, so this copy is stable at the synced edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_din_q <= '0;
        else        r_din_q <= bus.data_in;
    end

    assign w_din = r_din_q;
`else
    assign w_h2  = bus.handshake_2;
    assign w_din = bus.data_in;
`endif

    assign w_phase_done = (r_state == REQ_1 || r_state == REQ_2) ? w_h2 : !w_h2;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state       <= IDLE;
            r_cmd_ready   <= 1'b1;
            r_rsp_valid   <= 1'b0;
            r_rsp_timeout <= 1'b0;
            r_rsp_data    <= '0;
            r_rsp_status  <= '0;
            r_addr        <= '0;
            r_rw          <= 1'b0;
            r_rav         <= 1'b0;
            r_data_out    <= '0;
            r_h1          <= 1'b0;
            r_cnt         <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (i_cmd_valid) begin
                        r_cmd_ready   <= 1'b0;
                        r_addr        <= i_cmd_addr;
                        r_rw          <= i_cmd_rw;
                        r_data_out    <= i_cmd_data;
                        r_rav         <= 1'b1;
                        r_rsp_data    <= '0;
                        r_rsp_status  <= '0;
                        r_rsp_timeout <= 1'b0;
                        r_cnt         <= '0;
                        r_state       <= SETUP;
                    end
                end
                SETUP: begin
                    r_h1    <= 1'b1;
                    r_cnt   <= '0;
                    r_state <= REQ_1;
                end
                REQ_1, ACK_1, REQ_2, ACK_2: begin
                    if (w_phase_done) begin
                        r_cnt <= '0;
                        case (r_state)
                            REQ_1: begin
                                if (r_rw) r_rsp_data <= w_din;
                                r_h1    <= 1'b0;
                                r_state <= ACK_1;
                            end
                            ACK_1: begin
                                r_h1    <= 1'b1;
                                r_state <= REQ_2;
                            end
                            REQ_2: begin
                                r_rsp_status <= w_din;
                                r_h1         <= 1'b0;
                                r_state      <= ACK_2;
                            end
                            default: begin
                                r_rav       <= 1'b0;
                                r_rsp_valid <= 1'b1;
                                r_state     <= RESP;
                            end
                        endcase
                    end else if (r_cnt == CNT_LAST) begin
                        // Abort: uncaptured fields keep the zeros loaded at accept.
                        r_h1          <= 1'b0;
                        r_rav         <= 1'b0;
                        r_rsp_timeout <= 1'b1;
                        r_rsp_valid   <= 1'b1;
                        r_state       <= RESP;
                    end else if (r_cnt != CNT_MAX) begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                RESP: begin
                    if (i_rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_cmd_ready <= 1'b1;
                        r_state     <= IDLE;
                    end
                end
                default: begin
                    r_h1        <= 1'b0;
                    r_rav       <= 1'b0;
                    r_rsp_valid <= 1'b0;
                    r_cmd_ready <= 1'b1;
                    r_state     <= IDLE;
                end
            endcase
        end
    end

    assign o_cmd_ready                = r_cmd_ready;
    assign o_rsp_valid                = r_rsp_valid;
    assign o_rsp_data                 = r_rsp_data;
    assign o_rsp_status               = r_rsp_status;
    assign o_rsp_timeout              = r_rsp_timeout;
    assign bus.reg_address            = r_addr;
    assign bus.rw                     = r_rw;
    assign bus.register_address_valid = r_rav;
    assign bus.data_out               = r_data_out;
    assign bus.handshake_1            = r_h1;
endmodule

// File: tb/tb_io_bus_master.sv
// Directed scoreboard bench for io_bus_master with a configurable-delay responder model.
module tb_io_bus_master;
    import io_bus_master_pkg::*;

    localparam int          ADDR_W          = 8;
    localparam int          TMO             = 16;
    localparam logic [31:0] SYS_INFO_0_DATA = 32'h5359_5330;
    localparam logic [7:0]  A_SYS_INFO_0    = 8'h00;
    localparam logic [7:0]  A_WR            = 8'h20;
    localparam logic [7:0]  A_RD            = 8'h31;
    localparam logic [7:0]  A_UNMAPPED      = 8'hFF;
`ifdef IO_BUS_MASTER_SYNC_EN
    localparam int SX = 2;
`else
    localparam int SX = 0;
`endif

    logic clk = 1'b0;
    logic rst_b = 1'b1;
    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic              cmd_valid = 1'b0;
    logic              cmd_ready;
    logic              cmd_rw = 1'b0;
    logic [ADDR_W-1:0] cmd_addr = '0;
    logic [DATA_W-1:0] cmd_data = '0;
    logic              rsp_valid;
    logic              rsp_ready = 1'b0;
    logic [DATA_W-1:0] rsp_data;
    logic [DATA_W-1:0] rsp_status;
    logic              rsp_timeout;

    io_bus_master_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus_if ();

    io_bus_master #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT_CYCLES(TMO)) dut (
        .clk           (clk),
        .reset         (rst_b),
        .i_cmd_valid   (cmd_valid),
        .o_cmd_ready   (cmd_ready),
        .i_cmd_rw      (cmd_rw),
        .i_cmd_addr    (cmd_addr),
        .i_cmd_data    (cmd_data),
        .o_rsp_valid   (rsp_valid),
        .i_rsp_ready   (rsp_ready),
        .o_rsp_data    (rsp_data),
        .o_rsp_status  (rsp_status),
        .o_rsp_timeout (rsp_timeout),
        .bus           (bus_if.master)
    );

    function automatic logic [31:0] model_data(input logic [7:0] a);
        return (a == A_SYS_INFO_0) ? SYS_INFO_0_DATA : {16'hC0DE, 8'h00, a};
    endfunction

    function automatic logic [31:0] model_status(input logic [7:0] a);
        return (a == A_SYS_INFO_0) ? ~SYS_INFO_0_DATA : (32'h5AA5_0000 | {24'h0, a});
    endfunction

    function automatic bus_rsp_t mk_rsp(input logic [31:0] d, input logic [31:0] s, input logic t);
        bus_rsp_t r;
        r.data = d; r.status = s; r.timeout = t;
        return r;
    endfunction

    // Responder: acknowledge follows handshake_1 delayed by rsp_wait cycles (0 = combinational).
    int unsigned rsp_wait = 0;
    logic        stuck_mode = 1'b0;
    logic [7:0]  h1_hist = '0;
    logic [8:0]  w_h1_line;
    logic        r_stuck = 1'b0, r_ph2 = 1'b0, r_first_seen = 1'b0;
    logic [31:0] seen_data_out = '0;
    logic        seen_rav = 1'b0, seen_rw = 1'b0;
    logic [7:0]  seen_addr = '0;
    logic        w_sel, w_h2;
    int          overlap_err = 0;

    assign w_h1_line = {h1_hist, bus_if.handshake_1};
    assign w_sel     = bus_if.register_address_valid && (bus_if.reg_address != A_UNMAPPED);
    assign w_h2      = r_stuck || (w_sel && w_h1_line[rsp_wait]);
    assign bus_if.handshake_2 = w_h2;
    assign bus_if.data_in = w_sel ? (r_ph2 ? model_status(bus_if.reg_address)
                                           : model_data(bus_if.reg_address)) : 'z;

    always @(posedge clk) begin
        h1_hist <= {h1_hist[6:0], bus_if.handshake_1};
        if (!stuck_mode)    r_stuck <= 1'b0;
        else if (w_h2)      r_stuck <= 1'b1;
        if (!bus_if.register_address_valid)             r_ph2 <= 1'b0;
        else if (h1_hist[0] && !bus_if.handshake_1)     r_ph2 <= 1'b1;
        if (cmd_valid && cmd_ready) r_first_seen <= 1'b0;
        else if (w_h2 && !r_ph2 && !r_first_seen) begin
            r_first_seen  <= 1'b1;
            seen_data_out <= bus_if.data_out;
            seen_rav      <= bus_if.register_address_valid;
            seen_addr     <= bus_if.reg_address;
            seen_rw       <= bus_if.rw;
        end
    end

    always @(negedge clk) begin
        if (rst_b && bus_if.handshake_1 && (cmd_ready || rsp_valid || !bus_if.register_address_valid))
            overlap_err <= overlap_err + 1;
    end

    int       n_cmp = 0;
    int       n_bad = 0;
    bus_rsp_t sb[$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic bound_fail(input string tag);
        n_cmp++;
        n_bad++;
        $error("FAIL %s: wait bound expired", tag);
    endtask

    task automatic check_rsp(input string tag);
        bus_rsp_t e;
        if (sb.size() == 0) begin
            bound_fail({tag, " scoreboard empty"});
            return;
        end
        e = sb.pop_front();
        check({tag, " data"},    rsp_data,    e.data);
        check({tag, " status"},  rsp_status,  e.status);
        check({tag, " timeout"}, rsp_timeout, e.timeout);
    endtask

    // Latency is counted inclusively: accept cycle is cycle 1, first rsp_valid cycle is cycle N.
    task automatic do_cmd(input string tag, input logic rw, input logic [7:0] addr,
                          input logic [31:0] data, input bus_rsp_t exp, input int exp_lat);
        int  t_acc, t_rsp;
        bit  ok;
        bus_rsp_t dummy;
        sb.push_back(exp);
        @(negedge clk);
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (cmd_ready) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        if (!ok) begin bound_fail({tag, " cmd_ready"}); dummy = sb.pop_back(); return; end
        cmd_valid = 1'b1; cmd_rw = rw; cmd_addr = addr; cmd_data = data;
        t_acc = int'(cyc);
        @(negedge clk);
        cmd_valid = 1'b0; cmd_data = '0; cmd_addr = '0; cmd_rw = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (rsp_valid) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        if (!ok) begin bound_fail({tag, " rsp_valid"}); dummy = sb.pop_back(); return; end
        t_rsp = int'(cyc);
        check({tag, " latency"}, 64'(t_rsp - t_acc + 1), 64'(exp_lat));
        check_rsp(tag);
        check({tag, " h1 in resp"}, bus_if.handshake_1, 1'b0);
        check({tag, " rav in resp"}, bus_if.register_address_valid, 1'b0);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        check({tag, " rsp_valid drop"}, rsp_valid, 1'b0);
        check({tag, " cmd_ready back"}, cmd_ready, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int  acc_t[2];
        int  rsp_t[2];
        int  n_acc, n_rsp;
        bit  upd, ok;

        #1 rst_b = 1'b0;
        #2;
        check("rst cmd_ready",   cmd_ready, 1'b1);
        check("rst rsp_valid",   rsp_valid, 1'b0);
        check("rst rsp_data",    rsp_data, 32'h0);
        check("rst rsp_status",  rsp_status, 32'h0);
        check("rst rsp_timeout", rsp_timeout, 1'b0);
        check("rst reg_address", bus_if.reg_address, 8'h0);
        check("rst rw",          bus_if.rw, 1'b0);
        check("rst rav",         bus_if.register_address_valid, 1'b0);
        check("rst data_out",    bus_if.data_out, 32'h0);
        check("rst h1",          bus_if.handshake_1, 1'b0);
        repeat (3) @(negedge clk);
        rst_b = 1'b1;
        repeat (2) @(negedge clk);

        rsp_wait = 0;
        do_cmd("rd sysinfo0", 1'b1, A_SYS_INFO_0, 32'hDEAD_BEEF,
               mk_rsp(SYS_INFO_0_DATA, ~SYS_INFO_0_DATA, 1'b0), 7 + 4 * SX);
        check("rd sysinfo0 addr seen", seen_addr, A_SYS_INFO_0);
        check("rd sysinfo0 rw seen",   seen_rw, 1'b1);

        do_cmd("wr 0wait", 1'b0, A_WR, 32'h1234_5678,
               mk_rsp(32'h0, model_status(A_WR), 1'b0), 7 + 4 * SX);
        check("wr 0wait data_out seen", seen_data_out, 32'h1234_5678);
        check("wr 0wait rav seen",      seen_rav, 1'b1);
        check("wr 0wait rw seen",       seen_rw, 1'b0);

        rsp_wait = 5;
        do_cmd("wr 5wait", 1'b0, A_WR, 32'h1234_5678,
               mk_rsp(32'h0, model_status(A_WR), 1'b0), 7 + 4 * 5 + 4 * SX);
        check("wr 5wait data_out seen", seen_data_out, 32'h1234_5678);
        check("wr 5wait rav seen",      seen_rav, 1'b1);

        do_cmd("rd 5wait", 1'b1, A_RD, 32'h0,
               mk_rsp(model_data(A_RD), model_status(A_RD), 1'b0), 7 + 4 * 5 + 4 * SX);

        rsp_wait = 0;
        do_cmd("rd unmapped", 1'b1, A_UNMAPPED, 32'h0, mk_rsp(32'h0, 32'h0, 1'b1), 2 + TMO + 1);

        stuck_mode = 1'b1;
        do_cmd("rd stuck ack", 1'b1, A_RD, 32'h0,
               mk_rsp(model_data(A_RD), 32'h0, 1'b1), 3 + SX + TMO + 1);
        stuck_mode = 1'b0;
        repeat (6) @(negedge clk);

        // Reset while the master waits in REQ_2.
        rsp_wait = 5;
        cmd_valid = 1'b1; cmd_rw = 1'b1; cmd_addr = A_RD;
        @(negedge clk);
        cmd_valid = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (bus_if.handshake_1 && r_ph2) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        if (!ok) bound_fail("reset REQ_2 entry");
        rst_b = 1'b0;
        @(posedge clk);
        #1;
        check("reset mid h1",        bus_if.handshake_1, 1'b0);
        check("reset mid rav",       bus_if.register_address_valid, 1'b0);
        check("reset mid cmd_ready", cmd_ready, 1'b1);
        check("reset mid rsp_valid", rsp_valid, 1'b0);
        @(negedge clk);
        rst_b = 1'b1;
        repeat (10) @(negedge clk);
        check("reset mid no rsp", rsp_valid, 1'b0);

        rsp_wait = 0;
        do_cmd("rd after reset", 1'b1, A_RD, 32'h0,
               mk_rsp(model_data(A_RD), model_status(A_RD), 1'b0), 7 + 4 * SX);

        // Back-to-back reads with rsp_ready tied high.
        rsp_ready = 1'b1;
        sb.push_back(mk_rsp(SYS_INFO_0_DATA, ~SYS_INFO_0_DATA, 1'b0));
        sb.push_back(mk_rsp(model_data(A_RD), model_status(A_RD), 1'b0));
        @(negedge clk);
        cmd_valid = 1'b1; cmd_rw = 1'b1; cmd_addr = A_SYS_INFO_0;
        n_acc = 0; n_rsp = 0; upd = 1'b0;
        acc_t = '{0, 0}; rsp_t = '{0, 0};
        for (int i = 0; i < 100 && n_rsp < 2; i++) begin
            if (upd) begin
                if (n_acc == 1) cmd_addr = A_RD;
                else cmd_valid = 1'b0;
                upd = 1'b0;
            end
            if (cmd_valid && cmd_ready && n_acc < 2) begin
                acc_t[n_acc] = int'(cyc);
                n_acc++;
                upd = 1'b1;
            end
            if (rsp_valid && n_rsp < 2) begin
                rsp_t[n_rsp] = int'(cyc);
                check_rsp(n_rsp == 0 ? "b2b first" : "b2b second");
                n_rsp++;
            end
            @(negedge clk);
        end
        cmd_valid = 1'b0;
        rsp_ready = 1'b0;
        if (n_rsp < 2 || n_acc < 2) begin
            bound_fail("b2b responses");
        end else begin
            check("b2b first latency",  64'(rsp_t[0] - acc_t[0] + 1), 64'(7 + 4 * SX));
            check("b2b second accept",  64'(acc_t[1]), 64'(rsp_t[0] + 1));
            check("b2b second latency", 64'(rsp_t[1] - acc_t[1] + 1), 64'(7 + 4 * SX));
        end

        repeat (3) @(negedge clk);
        check("handshake overlap", 64'(overlap_err), 64'(0));
        check("scoreboard drained", 64'(sb.size()), 64'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/io_bus_master.md
Name: io_bus_master

Overview:
- Single master of the internal 32-bit IO bus. Sits between the host command decoder (SPI/UART packet layer) and all bus subsystems (SYS_info, PWM, QE, ...).
- Turns one host command into the bus transaction that each subsystem's bus_FSM expects: address/RW setup, then two 4-phase handshakes on handshake_1/handshake_2.
- Returns the data word, the status word and a timeout flag to the host side.

Parameters:
- ADDR_W, 8, width of reg_address.
- DATA_W, 32, bus data width.
- TIMEOUT_CYCLES, 1000, maximum clk cycles to wait in any handshake phase before abort; must be >= 2.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low
- cmd_valid  in  1  host command present
- cmd_ready  out  1  master can accept a command
- cmd_rw  in  1  1 = read from subsystem, 0 = write to subsystem
- cmd_addr  in  ADDR_W  register number
- cmd_data  in  DATA_W  write data (ignored for read)
- rsp_valid  out  1  response present
- rsp_ready  in  1  host accepts response
- rsp_data  out  DATA_W  captured data word (read) or 0 (write)
- rsp_status  out  DATA_W  captured status word
- rsp_timeout  out  1  transaction aborted by timeout
- bus_reg_address  out  ADDR_W  to IO_bus.reg_address
- bus_rw  out  1  to IO_bus.RW
- bus_register_address_valid  out  1  to IO_bus.register_address_valid
- bus_data_out  out  DATA_W  to IO_bus.data_out
- bus_handshake_1  out  1  master strobe
- bus_handshake_2  in  1  subsystem acknowledge
- bus_data_in  in  DATA_W  IO_bus.data_in; high-Z when no subsystem is enabled

Behaviour:
- Reset: every output is 0, except cmd_ready = 1. State is IDLE. The timeout counter is 0.
- Reset mid-transaction: returns to IDLE immediately and drops handshake_1 and register_address_valid. No response is generated.
- All bus outputs are registered.
- bus_reg_address, bus_rw and bus_data_out are held stable from SETUP through ACK_2.
- FSM states:
  - IDLE: cmd_ready = 1. On cmd_valid, latch cmd_rw, cmd_addr and cmd_data onto the bus outputs, set register_address_valid = 1, go to SETUP. cmd_ready is 0 in every other state.
  - SETUP: one cycle for address decode and subsystem_enable to settle, then go to REQ_1.
  - REQ_1: handshake_1 = 1. Wait for handshake_2 = 1.
    - On that cycle, if rw = 1, capture bus_data_in into rsp_data.
    - For writes, the subsystem latches data_out on this handshake.
    - Go to ACK_1.
  - ACK_1: handshake_1 = 0. Wait for handshake_2 = 0, then go to REQ_2.
  - REQ_2: handshake_1 = 1. Wait for handshake_2 = 1, capture bus_data_in into rsp_status, go to ACK_2.
  - ACK_2: handshake_1 = 0. Wait for handshake_2 = 0, then drop register_address_valid and go to RESP.
  - RESP: rsp_valid = 1, and the rsp_* fields are held. On rsp_ready, go to IDLE. rsp_ready in the same cycle as rsp_valid's first assertion is legal: 1-cycle RESP.
- Minimum latency with a zero-wait responder: cmd accept to rsp_valid = 7 cycles.
- Timeout:
  - The counter clears on entry to each of REQ_1, ACK_1, REQ_2 and ACK_2, and increments each cycle spent waiting.
  - At TIMEOUT_CYCLES - 1 it aborts: handshake_1 = 0, register_address_valid = 0, go to RESP.
  - In the aborted response, rsp_timeout = 1, and any field not yet captured reads 0.
  - The counter saturates and never wraps.
- Unmapped address: no subsystem drives handshake_2, so the transaction ends in a timeout.
- bus_data_in is sampled only on qualifying handshake_2 edges, so high-Z outside those edges never propagates.
- A new cmd_valid during a transaction is ignored; the host holds it until cmd_ready.

Optional Feature:
- Macro: IO_BUS_MASTER_SYNC_EN.
- Defined: bus_handshake_2 passes through a 2-flop synchronizer before the FSM. Every handshake-phase wait gains 2 cycles, so minimum latency becomes 15 cycles. Data is captured from a register sampled on the synchronized edge, taken one cycle after raw handshake_2; subsystems hold data_in until handshake_1 falls.
- Undefined: handshake_2 is used directly, with 7-cycle minimum latency.

Decomposition:
- Package types gains:
  - the bus_master_state_t enum (IDLE, SETUP, REQ_1, ACK_1, REQ_2, ACK_2, RESP);
  - the DATA_W constant;
  - a bus_rsp_t struct {data, status, timeout}.
- Register base addresses stay in global_constants.sv.
- One sub-module: sync_2ff (single-bit 2-flop synchronizer), instantiated only under IO_BUS_MASTER_SYNC_EN.

Test Plan:
- Read SYS_INFO_0 against a real SYS_info instance -> rsp_data = SYS_INFO_0_DATA, rsp_status = ~SYS_INFO_0_DATA, rsp_timeout = 0.
- Write 0x1234_5678 to a responder model with 0-wait and then 5-wait acks -> model sees data_out = 0x1234_5678 with register_address_valid = 1 at its first handshake_2. Latency is 7 cycles for 0-wait, plus 4 x 5 for 5-wait.
- Read unmapped address 0xFF, TIMEOUT_CYCLES = 16 -> rsp_valid 16 cycles after REQ_1 entry, rsp_timeout = 1, rsp_data = 0, rsp_status = 0, handshake_1 = 0.
- Responder acks REQ_1, then holds handshake_2 high forever -> abort out of ACK_1, rsp_data = the captured word, rsp_status = 0, rsp_timeout = 1.
- Assert reset during REQ_2 -> next cycle: handshake_1 = 0, register_address_valid = 0, cmd_ready = 1, no rsp_valid. A following read completes normally.
- Back-to-back reads with rsp_ready tied high -> second cmd accepted on the cycle after RESP. No handshake overlap. With IO_BUS_MASTER_SYNC_EN, latency is 15 cycles each.
